hilo_mul_sequencer: RTL and testbench

- Iterative multiply sequencer that owns the HiLo register write path for mult, multu and maddu.
- Replaces the single-cycle multiplier path feeding HiLo.
- Accepts one request from EX and runs a shift-add multiply over several cycles.
- Produces a one-cycle HiLo write strobe with the 64-bit result, and stalls the pipeline for a new multiply or an mfhi/mflo while busy.

---
 rtl/hilo_mul_sequencer.sv | 173 +++++++++++++++++
 tb/tb_hilo_mul_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mul_sequencer.sv
// Iterative shift-add multiplier owning the HiLo write path for mult, multu and maddu.
// Optional MUL_EARLY_TERM_EN ends RUN as soon as the remaining multiplier bits are all zero.
module hilo_mul_sequencer #(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [63:0] hilo_in,
    input  logic        mf_req,
    output logic        stall,
    output logic        busy,
    output logic        hilo_we,
    output logic [63:0] hilo_out
);

    localparam int unsigned ITER   = 32 / BITS_PER_CYCLE;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned ACC_W  = 64;
    localparam int unsigned OPND_W = 32;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_MADDU = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    mcand_q, mcand_d;
    logic [OPND_W-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic                maddu_q, maddu_d;
    logic [ACC_W-1:0]    snap_q, snap_d;
    logic [ACC_W-1:0]    hilo_out_d;
    logic                hilo_we_d;
    logic                busy_d;

    logic                is_signed;
    logic [OPND_W-1:0]   a_mag;
    logic [OPND_W-1:0]   b_mag;
    logic [ACC_W-1:0]    partial;
    logic [ACC_W-1:0]    acc_signed;
    logic [ACC_W-1:0]    acc_final;
    logic                run_last;

    // Stall only blocks newer work while a multiply is in flight; reset drops it at once.
    assign stall = busy & ~rst & (req_valid | mf_req);

    // Operand magnitudes for the signed op; raw operands otherwise.
    always_comb begin
        is_signed = (req_op == OP_MULT);
        a_mag     = (is_signed && op_a[OPND_W-1]) ? (~op_a + OPND_W'(1)) : op_a;
        b_mag     = (is_signed && op_b[OPND_W-1]) ? (~op_b + OPND_W'(1)) : op_b;
    end

    // Multiplicand times the low BITS_PER_CYCLE multiplier bits, already at the current shift.
    always_comb begin
        partial = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_q[i]) begin
                partial = partial + (mcand_q << i);
            end
        end
    end

    // Sign fix-up and maddu accumulation applied in FIX.
    always_comb begin
        acc_signed = neg_q ? (~acc_q + ACC_W'(1)) : acc_q;
        acc_final  = maddu_q ? (acc_signed + snap_q) : acc_signed;
    end

`ifdef MUL_EARLY_TERM_EN
    assign run_last = (cnt_q == LAST_ITER) || ((mplier_q >> BITS_PER_CYCLE) == '0);
`else
    assign run_last = (cnt_q == LAST_ITER);
`endif

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        maddu_d    = maddu_q;
        snap_d     = snap_q;
        hilo_out_d = hilo_out;
        hilo_we_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid && (req_op != OP_RSVD)) begin
                    acc_d    = '0;
                    mcand_d  = ACC_W'(a_mag);
                    mplier_d = b_mag;
                    cnt_d    = '0;
                    neg_d    = is_signed & (op_a[OPND_W-1] ^ op_b[OPND_W-1]);
                    maddu_d  = (req_op == OP_MADDU);
                    snap_d   = hilo_in;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = acc_q + partial;
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_q >> BITS_PER_CYCLE;
                cnt_d    = cnt_q + CNT_W'(1);
                if (run_last) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                acc_d      = acc_final;
                hilo_out_d = acc_final;
                hilo_we_d  = 1'b1;
                state_d    = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            maddu_q  <= 1'b0;
            snap_q   <= '0;
            hilo_out <= '0;
            hilo_we  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            maddu_q  <= maddu_d;
            snap_q   <= snap_d;
            hilo_out <= hilo_out_d;
            hilo_we  <= hilo_we_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_hilo_mul_sequencer.sv
// Scoreboard bench for hilo_mul_sequencer: reference results from plain 64-bit arithmetic.
module tb_hilo_mul_sequencer;

    localparam int unsigned BPC = 1;
    localparam int unsigned N   = 32 / BPC;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [63:0] hilo_in;
    logic        mf_req;
    logic        stall;
    logic        busy;
    logic        hilo_we;
    logic [63:0] hilo_out;

    typedef struct {
        logic [63:0] val;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    hilo_mul_sequencer #(.BITS_PER_CYCLE(BPC)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_op   (req_op),
        .op_a     (op_a),
        .op_b     (op_b),
        .hilo_in  (hilo_in),
        .mf_req   (mf_req),
        .stall    (stall),
        .busy     (busy),
        .hilo_we  (hilo_we),
        .hilo_out (hilo_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] h);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            2'd0:    return {32'd0, a} * {32'd0, b};
            2'd1:    return 64'(sa * sb);
            default: return ({32'd0, a} * {32'd0, b}) + h;
        endcase
    endfunction

    // Cycles from acceptance to the HiLo write.
    function automatic int unsigned lat_of(input logic [1:0] op, input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
        logic [31:0] m;
        int unsigned k;
        m = (op == 2'd1 && b[31]) ? (~b + 32'd1) : b;
        k = 1;
        while (k < N && (m >> (k * BPC)) != 32'd0) k++;
        return k + 2;
`else
        if (op == 2'd3) return 0;
        if (b == 32'hDEAD_0000) return N + 2;
        return N + 2;
`endif
    endfunction

    task automatic wait_idle();
        int unsigned w = 0;
        while (busy && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("wait_idle", 64'(busy), 64'd0);
    endtask

    // Drive one request in an idle cycle and record its expected write.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] h);
        exp_t e;
        wait_idle();
        req_valid = 1'b1;
        req_op    = op;
        op_a      = a;
        op_b      = b;
        hilo_in   = h;
        e.val     = model(op, a, b, h);
        e.cyc     = cyc + lat_of(op, b);
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 2'($urandom_range(0, 2));
        op_a      = $urandom;
        op_b      = $urandom;
        hilo_in   = {$urandom, $urandom};
    endtask

    // Monitor: every HiLo write must match the oldest expectation in value and cycle.
    always @(negedge clk) begin
        if (!rst && hilo_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_we @cyc %0d: got hilo_out=%h want no write", cyc, hilo_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("hilo_out", hilo_out, e.val);
                check("we_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        int unsigned t0;
        int unsigned lat1;
        exp_t e;
        logic [31:0] a2;
        logic [31:0] b2;

        rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; op_a = '0; op_b = '0;
        hilo_in = '0; mf_req = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_we", 64'(hilo_we), 64'd0);
        check("rst_hilo_out", hilo_out, 64'd0);
        rst = 1'b0;
        mf_req = 1'b0;
        @(negedge clk);

        // multu 3*5 with busy window check
        lat1 = lat_of(2'd0, 32'd5);
        issue(2'd0, 32'd3, 32'd5, 64'd0);
        for (int c = 1; c <= int'(lat1); c++) begin
            check("busy_win", 64'(busy), 64'd1);
            @(negedge clk);
        end
        check("busy_end", 64'(busy), 64'd0);

        issue(2'd1, 32'hFFFF_FFFE, 32'd7, 64'd0);
        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0);
        issue(2'd2, 32'd2, 32'd3, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(2'd1, 32'h8000_0000, 32'h8000_0000, 64'd0);
        issue(2'd0, 32'd7, 32'd3, 64'd0);
        issue(2'd1, 32'd0, 32'hFFFF_FFFF, 64'd0);

        // Reserved op is ignored
        wait_idle();
        req_valid = 1'b1; req_op = 2'd3; op_a = 32'd9; op_b = 32'd9; mf_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("rsvd_stall", 64'(stall), 64'd0);
            @(negedge clk);
            check("rsvd_busy", 64'(busy), 64'd0);
        end
        req_valid = 1'b0; mf_req = 1'b0;

        // mf_req held from acceptance; second request waits through DONE
        wait_idle();
        lat1 = lat_of(2'd1, 32'd7);
        t0 = cyc;
        req_valid = 1'b1; req_op = 2'd1; op_a = 32'hFFFF_FFFE; op_b = 32'd7; hilo_in = '0;
        mf_req = 1'b1;
        e.val = model(2'd1, 32'hFFFF_FFFE, 32'd7, 64'd0);
        e.cyc = t0 + lat1;
        exp_q.push_back(e);
        for (int c = 0; c <= int'(lat1) + 1; c++) begin
            if (c == 1) begin
                req_valid = 1'b0; op_a = $urandom; op_b = $urandom;
            end
            if (c == int'(lat1)) begin
                a2 = $urandom; b2 = $urandom;
                req_valid = 1'b1; req_op = 2'd0; op_a = a2; op_b = b2;
                e.val = model(2'd0, a2, b2, 64'd0);
                e.cyc = t0 + lat1 + 1 + lat_of(2'd0, b2);
                exp_q.push_back(e);
            end
            #1;
            check("mf_stall", 64'(stall), 64'((c >= 1) && (c <= int'(lat1))));
            @(negedge clk);
        end
        req_valid = 1'b0; mf_req = 1'b0;
        op_a = $urandom; op_b = $urandom;

        // Reset mid-RUN discards the operation
        wait_idle();
        t0 = cyc;
        issue(2'd0, $urandom, 32'hFFFF_FFFF, 64'd0);
        while (cyc < t0 + 10) @(negedge clk);
        rst = 1'b1; mf_req = 1'b1; req_valid = 1'b1; req_op = 2'd0;
        #1;
        check("rst_mid_stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 40; c++) begin
            check("post_rst_busy", 64'(busy), 64'd0);
            #1;
            check("post_rst_stall", 64'(stall), 64'd0);
            @(negedge clk);
        end
        mf_req = 1'b0;
        issue(2'd0, 32'd4, 32'd4, 64'd0);

        // Randomized operations
        for (int i = 0; i < 25; i++) begin
            logic [31:0] rb;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            issue(2'($urandom_range(0, 2)), $urandom, rb, {$urandom, $urandom});
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
